perf_cycle_counter_bank: RTL and testbench

- Multi-channel cycle-measurement block; successor to the single free-running cycle counter.
- Each channel measures the cycle distance between a start pulse and a stop pulse.
- Each channel latches the result, flags overflow, and optionally accumulates across runs.
- Results are read back through a registered select/read port by the Unet wrapper control logic for SSD-platform latency profiling.

---
 rtl/perf_cycle_counter_bank_if.sv | 28 ++
 rtl/perf_cycle_counter_bank.sv | 148 ++++++++++++++
 tb/tb_perf_cycle_counter_bank.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_cycle_counter_bank_if.sv
// Bus bundle for perf_cycle_counter_bank: per-channel controls, status flags, and the read port.
interface perf_cycle_counter_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned SEL_W  = 2
) ();
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic [NUM_CH-1:0] clear;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] ovf;
    logic              rd_req;
    logic [SEL_W-1:0]  rd_sel;
    logic              rd_valid;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_err;

    modport master (
        output start, stop, clear, rd_req, rd_sel,
        input  busy, done, ovf, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  start, stop, clear, rd_req, rd_sel,
        output busy, done, ovf, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/perf_cycle_counter_bank.sv
// Multi-channel start/stop cycle measurement with overflow flags, optional accumulation,
// and a registered select/read port.
module perf_cycle_counter_bank #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned SATURATE = 1,
    parameter int unsigned ACCUM    = 0,
    parameter int unsigned SEL_W    = 2
) (
    input logic                       clk,
    input logic                       rst,
    perf_cycle_counter_bank_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state     [NUM_CH];
    logic [WIDTH-1:0]  count     [NUM_CH];
    logic [WIDTH-1:0]  result    [NUM_CH];
    logic [WIDTH-1:0]  count_inc [NUM_CH];
    logic [WIDTH-1:0]  meas      [NUM_CH];
    logic [WIDTH:0]    sum       [NUM_CH];
    logic [WIDTH-1:0]  res_nxt   [NUM_CH];
    logic [NUM_CH-1:0] at_max;
    logic [NUM_CH-1:0] finish;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] busy_q;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] ovf_q;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_err;
    logic              rd_valid_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic              rd_err_q;

    // Per-channel arithmetic: saturating/wrapping increment, completion value, next result.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            at_max[i]    = &count[i];
            count_inc[i] = count[i] + WIDTH'(1);
            if (at_max[i]) count_inc[i] = (SATURATE != 0) ? '1 : '0;
            finish[i]    = !bus.clear[i] &&
                           ((state[i] == RUN && bus.stop[i]) ||
                            (state[i] != RUN && bus.start[i] && bus.stop[i]));
            meas[i]      = (state[i] == RUN) ? count_inc[i] : '0;
            sum[i]       = '0;
            if (ACCUM != 0) begin
                sum[i] = {1'b0, result[i]} + {1'b0, meas[i]};
                if (sum[i][WIDTH] && SATURATE != 0) sum[i][WIDTH-1:0] = '1;
            end else begin
                sum[i] = {1'b0, meas[i]};
            end
            ovf_set[i]   = (state[i] == RUN && at_max[i] && !bus.clear[i]) ||
                           (finish[i] && sum[i][WIDTH]);
            res_nxt[i]   = result[i];
            if (bus.clear[i])   res_nxt[i] = '0;
            else if (finish[i]) res_nxt[i] = sum[i][WIDTH-1:0];
        end
    end

    // Read mux sees the post-edge result so a same-edge completion is returned.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                sel_data = res_nxt[i];
                sel_err  = 1'b0;
            end
        end
    end

    // Channel FSMs, counters, results and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]  <= IDLE;
                count[i]  <= '0;
                result[i] <= '0;
            end
            busy_q <= '0;
            done_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                result[i] <= res_nxt[i];
                if (ovf_set[i]) ovf_q[i] <= 1'b1;
                if (bus.clear[i]) begin
                    state[i]  <= IDLE;
                    count[i]  <= '0;
                    ovf_q[i]  <= 1'b0;
                    busy_q[i] <= 1'b0;
                    done_q[i] <= 1'b0;
                end else begin
                    case (state[i])
                        IDLE, DONE: begin
                            if (bus.start[i] && bus.stop[i]) begin
                                state[i]  <= DONE;
                                busy_q[i] <= 1'b0;
                                done_q[i] <= 1'b1;
                            end else if (bus.start[i]) begin
                                state[i]  <= RUN;
                                count[i]  <= '0;
                                busy_q[i] <= 1'b1;
                                done_q[i] <= 1'b0;
                            end
                        end
                        RUN: begin
                            if (bus.stop[i]) begin
                                state[i]  <= DONE;
                                busy_q[i] <= 1'b0;
                                done_q[i] <= 1'b1;
                            end else begin
                                count[i] <= count_inc[i];
                            end
                        end
                        default: begin
                            state[i]  <= IDLE;
                            busy_q[i] <= 1'b0;
                            done_q[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Registered read port; data and error hold between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                rd_data_q <= sel_data;
                rd_err_q  <= sel_err;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_err   = rd_err_q;
endmodule

// File: tb/tb_perf_cycle_counter_bank.sv
// Directed bench for perf_cycle_counter_bank across three parameter sets.
module tb_perf_cycle_counter_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // a: 3 channels, 64-bit, saturate, overwrite
    perf_cycle_counter_bank_if #(.NUM_CH(3), .WIDTH(64), .SEL_W(2)) a_if ();
    // b: 4 channels, 8-bit, saturate, accumulate
    perf_cycle_counter_bank_if #(.NUM_CH(4), .WIDTH(8),  .SEL_W(2)) b_if ();
    // c: 4 channels, 8-bit, wrap, overwrite
    perf_cycle_counter_bank_if #(.NUM_CH(4), .WIDTH(8),  .SEL_W(2)) c_if ();

    perf_cycle_counter_bank #(.NUM_CH(3), .WIDTH(64), .SATURATE(1), .ACCUM(0), .SEL_W(2))
        dut_a (.clk(clk), .rst(rst), .bus(a_if));
    perf_cycle_counter_bank #(.NUM_CH(4), .WIDTH(8), .SATURATE(1), .ACCUM(1), .SEL_W(2))
        dut_b (.clk(clk), .rst(rst), .bus(b_if));
    perf_cycle_counter_bank #(.NUM_CH(4), .WIDTH(8), .SATURATE(0), .ACCUM(0), .SEL_W(2))
        dut_c (.clk(clk), .rst(rst), .bus(c_if));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input logic [1:0] sel, input logic [63:0] exp_d, input logic exp_e,
                          input string tag);
        a_if.rd_req = 1'b1;
        a_if.rd_sel = sel;
        tick();
        a_if.rd_req = 1'b0;
        check({tag, "_vld"}, 64'(a_if.rd_valid), 64'd1);
        check({tag, "_dat"}, a_if.rd_data, exp_d);
        check({tag, "_err"}, 64'(a_if.rd_err), 64'(exp_e));
    endtask

    task automatic read_b(input logic [1:0] sel, input logic [63:0] exp_d, input string tag);
        b_if.rd_req = 1'b1;
        b_if.rd_sel = sel;
        tick();
        b_if.rd_req = 1'b0;
        check({tag, "_vld"}, 64'(b_if.rd_valid), 64'd1);
        check({tag, "_dat"}, 64'(b_if.rd_data), exp_d);
    endtask

    task automatic read_c(input logic [1:0] sel, input logic [63:0] exp_d, input string tag);
        c_if.rd_req = 1'b1;
        c_if.rd_sel = sel;
        tick();
        c_if.rd_req = 1'b0;
        check({tag, "_vld"}, 64'(c_if.rd_valid), 64'd1);
        check({tag, "_dat"}, 64'(c_if.rd_data), exp_d);
    endtask

    initial begin
        a_if.start = '0; a_if.stop = '0; a_if.clear = '0; a_if.rd_req = 1'b0; a_if.rd_sel = '0;
        b_if.start = '0; b_if.stop = '0; b_if.clear = '0; b_if.rd_req = 1'b0; b_if.rd_sel = '0;
        c_if.start = '0; c_if.stop = '0; c_if.clear = '0; c_if.rd_req = 1'b0; c_if.rd_sel = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();

        // reset state and first read
        check("rst_busy", 64'(a_if.busy), 64'd0);
        check("rst_done", 64'(a_if.done), 64'd0);
        check("rst_ovf",  64'(a_if.ovf),  64'd0);
        check("rst_vld",  64'(a_if.rd_valid), 64'd0);
        read_a(2'd0, 64'd0, 1'b0, "rd0_rst");
        tick();
        check("rd_pulse", 64'(a_if.rd_valid), 64'd0);

        // ch0: start, stop 20 edges later
        a_if.start = 3'b001;
        tick();
        a_if.start = 3'b000;
        check("ch0_busy", 64'(a_if.busy[0]), 64'd1);
        repeat (19) tick();
        check("ch0_busy_end", 64'(a_if.busy[0]), 64'd1);
        a_if.stop = 3'b001;
        tick();
        a_if.stop = 3'b000;
        check("ch0_busy_off", 64'(a_if.busy[0]), 64'd0);
        check("ch0_done", 64'(a_if.done[0]), 64'd1);
        read_a(2'd0, 64'd20, 1'b0, "ch0_rd");
        tick();
        check("hold_vld", 64'(a_if.rd_valid), 64'd0);
        check("hold_dat", a_if.rd_data, 64'd20);

        // ch1: start+stop together -> zero-length run
        a_if.start = 3'b010;
        a_if.stop  = 3'b010;
        tick();
        a_if.start = 3'b000;
        a_if.stop  = 3'b000;
        check("ch1_done", 64'(a_if.done[1]), 64'd1);
        check("ch1_busy", 64'(a_if.busy[1]), 64'd0);
        read_a(2'd1, 64'd0, 1'b0, "ch1_rd");

        // out-of-range select
        read_a(2'd3, 64'd0, 1'b1, "sel3");

        // simultaneous starts, staggered stops: ch1=3, ch0=5, ch2=8
        a_if.start = 3'b111;
        tick();
        a_if.start = 3'b000;
        check("all_busy", 64'(a_if.busy), 64'd7);
        check("all_done", 64'(a_if.done), 64'd0);
        repeat (2) tick();
        a_if.stop = 3'b010;
        tick();
        a_if.stop = 3'b000;
        tick();
        a_if.stop = 3'b001;
        tick();
        a_if.stop = 3'b000;
        check("stag_busy", 64'(a_if.busy), 64'd4);
        repeat (2) tick();
        // stop and read ch2 on the same edge
        a_if.stop   = 3'b100;
        a_if.rd_req = 1'b1;
        a_if.rd_sel = 2'd2;
        tick();
        a_if.stop   = 3'b000;
        a_if.rd_req = 1'b0;
        check("same_vld", 64'(a_if.rd_valid), 64'd1);
        check("same_dat", a_if.rd_data, 64'd8);
        tick();

        // back-to-back reads
        a_if.rd_req = 1'b1;
        a_if.rd_sel = 2'd0;
        tick();
        check("b2b0_vld", 64'(a_if.rd_valid), 64'd1);
        check("b2b0_dat", a_if.rd_data, 64'd5);
        a_if.rd_sel = 2'd1;
        tick();
        check("b2b1_vld", 64'(a_if.rd_valid), 64'd1);
        check("b2b1_dat", a_if.rd_data, 64'd3);
        a_if.rd_sel = 2'd2;
        tick();
        a_if.rd_req = 1'b0;
        check("b2b2_vld", 64'(a_if.rd_valid), 64'd1);
        check("b2b2_dat", a_if.rd_data, 64'd8);
        tick();
        check("b2b_end", 64'(a_if.rd_valid), 64'd0);

        // reset mid-run at count 9
        a_if.start = 3'b001;
        tick();
        a_if.start = 3'b000;
        repeat (9) tick();
        check("pre_rst_busy", 64'(a_if.busy[0]), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 64'(a_if.busy), 64'd0);
        check("mid_rst_done", 64'(a_if.done), 64'd0);
        check("mid_rst_dat",  a_if.rd_data, 64'd0);
        a_if.stop = 3'b001;
        tick();
        a_if.stop = 3'b000;
        check("post_rst_stop_done", 64'(a_if.done), 64'd0);
        check("post_rst_stop_busy", 64'(a_if.busy), 64'd0);
        read_a(2'd0, 64'd0, 1'b0, "post_rst0");
        read_a(2'd1, 64'd0, 1'b0, "post_rst1");
        read_a(2'd2, 64'd0, 1'b0, "post_rst2");

        // accumulate on b ch2: 7 + 13
        b_if.start = 4'b0100;
        tick();
        b_if.start = 4'b0000;
        repeat (6) tick();
        b_if.stop = 4'b0100;
        tick();
        b_if.stop = 4'b0000;
        check("acc_done", 64'(b_if.done[2]), 64'd1);
        read_b(2'd2, 64'd7, "acc7");
        b_if.start = 4'b0100;
        tick();
        b_if.start = 4'b0000;
        check("acc_restart_done", 64'(b_if.done[2]), 64'd0);
        repeat (12) tick();
        b_if.stop = 4'b0100;
        tick();
        b_if.stop = 4'b0000;
        read_b(2'd2, 64'd20, "acc20");
        // zero-length run in DONE leaves an accumulated result alone
        b_if.start = 4'b0100;
        b_if.stop  = 4'b0100;
        tick();
        b_if.start = 4'b0000;
        b_if.stop  = 4'b0000;
        read_b(2'd2, 64'd20, "acc_zero");
        check("acc_ovf", 64'(b_if.ovf[2]), 64'd0);
        // clear wins over a start on the same edge
        b_if.clear = 4'b0100;
        b_if.start = 4'b0100;
        tick();
        b_if.clear = 4'b0000;
        b_if.start = 4'b0000;
        check("clr_busy", 64'(b_if.busy[2]), 64'd0);
        check("clr_done", 64'(b_if.done[2]), 64'd0);
        read_b(2'd2, 64'd0, "clr_rd");

        // 300-edge run on ch3 of b (saturate) and c (wrap)
        b_if.start = 4'b1000;
        c_if.start = 4'b1000;
        tick();
        b_if.start = 4'b0000;
        c_if.start = 4'b0000;
        repeat (299) tick();
        b_if.stop = 4'b1000;
        c_if.stop = 4'b1000;
        tick();
        b_if.stop = 4'b0000;
        c_if.stop = 4'b0000;
        check("sat_ovf", 64'(b_if.ovf[3]), 64'd1);
        check("sat_done", 64'(b_if.done[3]), 64'd1);
        check("wrap_ovf", 64'(c_if.ovf[3]), 64'd1);
        read_b(2'd3, 64'd255, "sat_rd");
        read_c(2'd3, 64'd44, "wrap_rd");
        check("wrap_ovf_other", 64'(c_if.ovf[2:0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
